// File: rtl/tiny_calc_pkg.sv
// Shared types and seven-segment codes for the tiny calculator.
// Segment vectors are {g,f,e,d,c,b,a}, active-low (0 = lit).
package tiny_calc_pkg;

    typedef logic [6:0] seg_t;

    localparam seg_t SEG_0     = 7'b1000000;
    localparam seg_t SEG_1     = 7'b1111001;
    localparam seg_t SEG_2     = 7'b0100100;
    localparam seg_t SEG_3     = 7'b0110000;
    localparam seg_t SEG_4     = 7'b0011001;
    localparam seg_t SEG_5     = 7'b0010010;
    localparam seg_t SEG_6     = 7'b0000010;
    localparam seg_t SEG_7     = 7'b1111000;
    localparam seg_t SEG_8     = 7'b0000000;
    localparam seg_t SEG_9     = 7'b0010000;
    localparam seg_t SEG_A     = 7'b0001000;
    localparam seg_t SEG_B     = 7'b0000011;
    localparam seg_t SEG_C     = 7'b1000110;
    localparam seg_t SEG_D     = 7'b0100001;
    localparam seg_t SEG_E     = 7'b0000110;
    localparam seg_t SEG_F     = 7'b0001110;
    localparam seg_t SEG_BLANK = 7'b1111111;

    // Hex nibble to segment pattern lookup.
    function automatic seg_t nibble_to_seg(input logic [3:0] nib);
        seg_t seg;
        case (nib)
            4'h0:    seg = SEG_0;
            4'h1:    seg = SEG_1;
            4'h2:    seg = SEG_2;
            4'h3:    seg = SEG_3;
            4'h4:    seg = SEG_4;
            4'h5:    seg = SEG_5;
            4'h6:    seg = SEG_6;
            4'h7:    seg = SEG_7;
            4'h8:    seg = SEG_8;
            4'h9:    seg = SEG_9;
            4'hA:    seg = SEG_A;
            4'hB:    seg = SEG_B;
            4'hC:    seg = SEG_C;
            4'hD:    seg = SEG_D;
            4'hE:    seg = SEG_E;
            default: seg = SEG_F;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/hex_to_7seg.sv
// Purely combinational hex digit to active-low seven-segment decoder.
module hex_to_7seg
    import tiny_calc_pkg::*;
(
    input  logic [3:0] nib_i,
    output seg_t       seg_o
);

    // Table lookup, no state.
    always_comb begin
        seg_o = nibble_to_seg(nib_i);
    end

endmodule

// File: rtl/tiny_calculator_core.sv
// Registered 4-bit hex adder driving four active-low seven-segment digits.
// Switches pass through a 2-flop synchroniser; a registered decode stage then
// updates all four digits together from one synchronised sample.
// Optional macro TINY_CALC_BLANK_EN: blank the carry digit when carry is 0.
module tiny_calculator_core
    import tiny_calc_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] SW,
    output seg_t       HEX0,
    output seg_t       HEX1,
    output seg_t       HEX2,
    output seg_t       HEX3
);

`ifdef TINY_CALC_BLANK_EN
    localparam seg_t HEX3_RST = SEG_BLANK;
`else
    localparam seg_t HEX3_RST = SEG_0;
`endif

    logic [7:0] sync1_q, sync2_q;
    logic [4:0] sum_d;
    seg_t       seg_a_d, seg_b_d, seg_sum_d, seg_carry_d, hex3_d;
    seg_t       hex0_q, hex1_q, hex2_q, hex3_q;

    // Two-flop synchroniser for the asynchronous switch inputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= SW;
            sync2_q <= sync1_q;
        end
    end

    // Zero-extended 5-bit sum of the synchronised operands.
    always_comb begin
        sum_d = {1'b0, sync2_q[3:0]} + {1'b0, sync2_q[7:4]};
    end

    hex_to_7seg u_dec_a     (.nib_i(sync2_q[3:0]),     .seg_o(seg_a_d));
    hex_to_7seg u_dec_b     (.nib_i(sync2_q[7:4]),     .seg_o(seg_b_d));
    hex_to_7seg u_dec_sum   (.nib_i(sum_d[3:0]),       .seg_o(seg_sum_d));
    hex_to_7seg u_dec_carry (.nib_i({3'b000, sum_d[4]}), .seg_o(seg_carry_d));

    // Carry digit selection: blank on zero carry only when the option is built in.
    always_comb begin
`ifdef TINY_CALC_BLANK_EN
        hex3_d = sum_d[4] ? seg_carry_d : SEG_BLANK;
`else
        hex3_d = seg_carry_d;
`endif
    end

    // Output registers: all four digits load on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hex0_q <= SEG_0;
            hex1_q <= SEG_0;
            hex2_q <= SEG_0;
            hex3_q <= HEX3_RST;
        end else begin
            hex0_q <= seg_a_d;
            hex1_q <= seg_b_d;
            hex2_q <= seg_sum_d;
            hex3_q <= hex3_d;
        end
    end

    assign HEX0 = hex0_q;
    assign HEX1 = hex1_q;
    assign HEX2 = hex2_q;
    assign HEX3 = hex3_q;

endmodule

// File: tb/tb_tiny_calculator_core.sv
// Self-checking bench for tiny_calculator_core.
// Honours TINY_CALC_BLANK_EN in its reference model when the build defines it.
module tb_tiny_calculator_core;

    logic       clk;
    logic       rst;
    logic [7:0] SW;
    logic [6:0] HEX0, HEX1, HEX2, HEX3;

    int passed = 0;
    int total  = 0;

    // Expected display vectors {HEX3,HEX2,HEX1,HEX0}, oldest first.
    logic [27:0] exp_q[$];

    tiny_calculator_core dut (
        .clk  (clk),
        .rst  (rst),
        .SW   (SW),
        .HEX0 (HEX0),
        .HEX1 (HEX1),
        .HEX2 (HEX2),
        .HEX3 (HEX3)
    );

    // ---------------- clock / reset block ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic logic [6:0] digit_code(input int v);
        case (v)
            0:  return 7'b1000000;
            1:  return 7'b1111001;
            2:  return 7'b0100100;
            3:  return 7'b0110000;
            4:  return 7'b0011001;
            5:  return 7'b0010010;
            6:  return 7'b0000010;
            7:  return 7'b1111000;
            8:  return 7'b0000000;
            9:  return 7'b0010000;
            10: return 7'b0001000;
            11: return 7'b0000011;
            12: return 7'b1000110;
            13: return 7'b0100001;
            14: return 7'b0000110;
            default: return 7'b0001110;
        endcase
    endfunction

    function automatic logic [27:0] model(input logic [7:0] sw);
        int a, b, s;
        logic [6:0] h3;
        a = int'(sw[3:0]);
        b = int'(sw[7:4]);
        s = a + b;
`ifdef TINY_CALC_BLANK_EN
        h3 = (s >= 16) ? digit_code(1) : 7'b1111111;
`else
        h3 = digit_code(s / 16);
`endif
        return {h3, digit_code(s % 16), digit_code(b), digit_code(a)};
    endfunction

    function automatic logic [27:0] observed();
        return {HEX3, HEX2, HEX1, HEX0};
    endfunction

    // ---------------- driver tasks ----------------
    // Advance one clock and land just after the edge for sampling/driving.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        logic [27:0] exp;
        rst = 1'b0;
        SW  = 8'hFF;
        ticks(4);
        #2 rst = 1'b1;   // asynchronous assert between edges
        #1;
        exp = model(8'h00);
        total++;
        if (observed() !== exp)
            $display("FAIL reset_immediate got=%h exp=%h", observed(), exp);
        else passed++;
        @(negedge clk);
        SW = 8'h00;
        @(negedge clk);
        rst = 1'b0;
        ticks(4);
        total++;
        if (observed() !== exp)
            $display("FAIL reset_hold got=%h exp=%h", observed(), exp);
        else passed++;
    endtask

    task automatic test_directed();
        logic [7:0] vec [4];
        logic [7:0] prev;
        logic [27:0] exp;
        vec[0] = 8'h23;   // A=3, B=2
        vec[1] = 8'h1E;   // A=E, B=1
        vec[2] = 8'h88;   // A=8, B=8 -> carry
        vec[3] = 8'hFF;   // A=F, B=F -> 0x1E
        prev = SW;
        for (int i = 0; i < 4; i++) begin
            SW = vec[i];
            ticks(2);
            exp = model(prev);
            total++;
            if (observed() !== exp)
                $display("FAIL directed_latency_%0d got=%h exp=%h", i, observed(), exp);
            else passed++;
            tick();
            exp = model(vec[i]);
            total++;
            if (observed() !== exp)
                $display("FAIL directed_value_%0d got=%h exp=%h", i, observed(), exp);
            else passed++;
            prev = vec[i];
        end
    endtask

    task automatic test_random();
        logic [7:0] v;
        logic [27:0] exp;
        for (int i = 0; i < 24; i++) begin
            v  = 8'($urandom_range(0, 255));
            SW = v;
            ticks(3);
            exp = model(v);
            total++;
            if (observed() !== exp)
                $display("FAIL random_%0d sw=%h got=%h exp=%h", i, v, observed(), exp);
            else passed++;
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] v;
        logic [27:0] exp;
        exp_q.delete();
        for (int i = 0; i < 40; i++) begin
            v  = 8'($urandom_range(0, 255));
            SW = v;
            exp_q.push_back(model(v));
            tick();
            if (exp_q.size() == 3) begin
                exp = exp_q.pop_front();
                total++;
                if (observed() !== exp)
                    $display("FAIL b2b_%0d got=%h exp=%h", i, observed(), exp);
                else passed++;
            end
        end
        while (exp_q.size() > 0) begin
            tick();
            exp = exp_q.pop_front();
            total++;
            if (observed() !== exp)
                $display("FAIL b2b_drain got=%h exp=%h", observed(), exp);
            else passed++;
        end
    endtask

    task automatic test_reset_mid();
        logic [27:0] exp;
        SW = 8'h88;
        ticks(3);
        exp = model(8'h88);
        total++;
        if (observed() !== exp)
            $display("FAIL mid_pre got=%h exp=%h", observed(), exp);
        else passed++;
        SW = 8'hFF;
        tick();            // new value is inside the synchroniser
        #2 rst = 1'b1;
        #1;
        exp = model(8'h00);
        total++;
        if (observed() !== exp)
            $display("FAIL mid_reset_immediate got=%h exp=%h", observed(), exp);
        else passed++;
        @(negedge clk);
        rst = 1'b0;
        tick();
        total++;
        if (observed() !== exp)
            $display("FAIL mid_release_first got=%h exp=%h", observed(), exp);
        else passed++;
        ticks(2);
        exp = model(8'hFF);
        total++;
        if (observed() !== exp)
            $display("FAIL mid_release_sample got=%h exp=%h", observed(), exp);
        else passed++;
    endtask

    // ---------------- sequence and final report ----------------
    initial begin
        rst = 1'b0;
        SW  = 8'h00;
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
